regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DATA_W, default 32, register value width.
REQ-003 SHALL have parameter DEPTH, default 2, long-latency-unit (LTU) holding FIFO entries, power of two.
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, cycles a non-empty FIFO may go ungranted before a forced grant.
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports wbEn/wbAddr/wbVal  in  1/ADDR_W/DATA_W  writeback-stage write request.
REQ-008 SHALL have port wbStall  out  1  hold request to writeback stage (upstream keeps its uop, drops wbEn).
REQ-009 SHALL have ports ltuValid/ltuAddr/ltuVal  in  1/ADDR_W/DATA_W  LTU result offer.
REQ-010 SHALL have port ltuReady  out  1  LTU result accepted when ltuValid && ltuReady.
REQ-011 SHALL have ports wrEn/wrAddr/wrVal  out  1/ADDR_W/DATA_W  single register-file write port.
REQ-012 SHALL have ports qAddr  in  ADDR_W, qHit  out  1, qVal  out  DATA_W  pending-write forwarding query.

Function
REQ-013 SHALL drive the write port combinationally in the same cycle: WB request passes through with zero latency.
REQ-014 SHALL give WB priority: wrEn/wrAddr/wrVal = WB request when wbEn=1 and wbStall=0.
REQ-015 SHALL grant the FIFO head when FIFO non-empty and (wbEn=0 or wbStall=1); head pops on grant.
REQ-016 SHALL assert wrEn=0 when neither WB nor FIFO head is granted.
REQ-017 SHALL suppress writes to address 0: wrEn=0 for a granted address-0 request; an address-0 head still pops.
REQ-018 SHALL drive ltuReady = (count != DEPTH) from registered count only; no same-cycle pass-through, accepted entries are writable no earlier than next cycle.
REQ-019 SHALL allow push and pop in the same cycle when not full; count unchanged.
REQ-020 SHALL keep FIFO pointers wrapping modulo DEPTH; count ranges 0..DEPTH.
REQ-021 SHALL maintain starvation counter: +1 each cycle FIFO non-empty and head not granted; cleared on head grant or FIFO empty; saturates at STARVE_LIMIT.
REQ-022 SHALL assert wbStall combinationally when counter == STARVE_LIMIT; that cycle head is granted regardless of wbEn.
REQ-023 SHALL, when a WB write is granted, invalidate every valid buffered entry with the same non-zero address (WB is younger); invalidated entries pop without writing.
REQ-024 SHALL treat a push in the same cycle as a matching WB grant as younger than WB: the pushed entry is kept.
REQ-025 SHALL drive qHit/qVal from the youngest valid buffered entry whose address equals qAddr (qAddr=0 never hits), combinationally.

Reset
REQ-026 SHALL on rst clear count, pointers, valid bits and starvation counter in the same clock edge.
REQ-027 SHALL hold wrEn=0, wbStall=0, qHit=0, ltuReady=1 while rst=1 and in the first cycle after; buffered entries are discarded on reset mid-operation.

Configuration
REQ-028 SHALL implement the forwarding query (REQ-025) only when macro RF_ARB_FWD_EN is defined.
REQ-029 SHALL without RF_ARB_FWD_EN keep qAddr/qHit/qVal ports, tie qHit=0 and qVal=0, and contain no compare logic.

Verification
REQ-030 SHALL cover: wbEn=1 addr 3 val 0x11, FIFO empty -> same cycle wrEn=1 addr 3 val 0x11, ltuReady=1.
REQ-031 SHALL cover: LTU pushes addr 5 val 0x22, wbEn=0 -> next cycle wrEn=1 addr 5 val 0x22, count returns 0.
REQ-032 SHALL cover: two LTU pushes, wbEn held 1 -> ltuReady=0 when full, wbStall=1 exactly 8 cycles after first non-empty cycle, head written that cycle, counter cleared.
REQ-033 SHALL cover: buffered addr 7 val 0x33, WB writes addr 7 val 0x44 -> wrVal 0x44, entry popped with no later write to addr 7.
REQ-034 SHALL cover: buffered addr 9 val 0x55 then 0x66, qAddr=9 -> qHit=1 qVal=0x66 (with RF_ARB_FWD_EN), qHit=0 without.
REQ-035 SHALL cover: rst asserted with FIFO full -> next cycle count 0, ltuReady=1, wrEn=0, no buffered write ever emitted.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: writeback requests have priority, LTU results queue in a small FIFO.
// Optional pending-write forwarding query is built only when RF_ARB_FWD_EN is defined.
module regfile_write_arbiter #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbEn,
    input  logic [ADDR_W-1:0] wbAddr,
    input  logic [DATA_W-1:0] wbVal,
    output logic              wbStall,
    input  logic              ltuValid,
    input  logic [ADDR_W-1:0] ltuAddr,
    input  logic [DATA_W-1:0] ltuVal,
    output logic              ltuReady,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrVal,
    input  logic [ADDR_W-1:0] qAddr,
    output logic              qHit,
    output logic [DATA_W-1:0] qVal
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_val  [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve;
    logic              rst_q;

    logic blocked;
    logic empty;
    logic full;
    logic push;
    logic wb_grant;
    logic head_grant;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Grant decision and write-port mux; outputs are quiet during reset and the cycle after.
    always_comb begin
        blocked    = rst | rst_q;
        empty      = (count == '0);
        full       = (count == CNT_W'(DEPTH));
        ltuReady   = rst | ~full;
        wbStall    = ~blocked & ~empty & (starve == STV_W'(STARVE_LIMIT));
        wb_grant   = ~blocked & wbEn & ~wbStall;
        head_grant = ~blocked & ~empty & (~wbEn | wbStall);
        push       = ltuValid & ltuReady & ~rst;
        wrEn       = 1'b0;
        wrAddr     = wbAddr;
        wrVal      = wbVal;
        if (wb_grant) begin
            wrEn = (wbAddr != '0);
        end else if (head_grant) begin
            wrAddr = ent_addr[head];
            wrVal  = ent_val[head];
            wrEn   = ent_valid[head] & (ent_addr[head] != '0);
        end
    end

    // FIFO control, stale-entry invalidation and starvation tracking.
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            starve    <= '0;
            ent_valid <= '0;
        end else begin
            if (wb_grant && (wbAddr != '0)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_addr[PTR_W'(i)] == wbAddr) begin
                        ent_valid[PTR_W'(i)] <= 1'b0;
                    end
                end
            end
            if (head_grant) begin
                ent_valid[head] <= 1'b0;
                head            <= ptr_inc(head);
            end
            // A same-cycle push is younger than the WB write, so it is set after invalidation.
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= ptr_inc(tail);
            end
            count <= count + CNT_W'(push) - CNT_W'(head_grant);
            if (empty || head_grant) begin
                starve <= '0;
            end else if (starve != STV_W'(STARVE_LIMIT)) begin
                starve <= starve + STV_W'(1);
            end
        end
    end

    // Entry payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= ltuAddr;
            ent_val[tail]  <= ltuVal;
        end
    end

`ifdef RF_ARB_FWD_EN
    logic [PTR_W-1:0] q_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        qHit  = 1'b0;
        qVal  = '0;
        q_idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            q_idx = head + PTR_W'(k);
            if (!blocked && (qAddr != '0) && ent_valid[q_idx] && (ent_addr[q_idx] == qAddr)) begin
                qHit = 1'b1;
                qVal = ent_val[q_idx];
            end
        end
    end
`else
    wire unused_qaddr = ^qAddr;

    assign qHit = 1'b0;
    assign qVal = '0;
`endif

endmodule
